// File: rtl/sar_avg_fifo_if.sv
// Read-side bundle of sar_avg_fifo: averaged-word FIFO head, occupancy and consumer ready.
interface sar_avg_fifo_if #(
  parameter int FIFO_DEPTH = 4
) ();
  logic [0:9]                    dout;
  logic                          dvalid;
  logic                          dready;
  logic [$clog2(FIFO_DEPTH):0]   level;

  modport master (output dout, output dvalid, output level, input dready);
  modport slave  (input dout, input dvalid, input level, output dready);
endinterface

// File: rtl/sar_avg_fifo.sv
// SAR post-processing: resynchronises CKO, averages 2^LOG2_AVG conversion results
// and queues the averaged words in a first-word-fall-through FIFO.
module sar_avg_fifo #(
  parameter int LOG2_AVG   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_en,
  input  logic           i_cko,
  input  logic [0:9]     i_data,
  input  logic           i_clr_ovf,
  output logic           o_ovf,
  sar_avg_fifo_if.master rd_if
);

  localparam int AW = 10 + LOG2_AVG;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic [AW-1:0] r_acc;
  logic          w_stb;
  logic          w_last;
  logic          w_push;
  logic [AW-1:0] w_sum;
  logic [0:9]    w_word;

  logic [0:9]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          r_ovf;
  logic          w_full;
  logic          w_pop;
  logic          w_write;
  logic          w_drop;

  // Synchroniser keeps running while disabled so a re-enable never sees a stale edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_cko;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_stb  = i_en & r_s2 & ~r_s3;
  assign w_sum  = r_acc + AW'(i_data);
  assign w_word = w_sum[AW-1 -: 10];
  assign w_push = w_stb & w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (!i_en) begin
      r_acc <= '0;
    end else if (w_stb) begin
      r_acc <= w_last ? '0 : w_sum;
    end
  end

  generate
    if (LOG2_AVG == 0) begin : g_no_cnt
      assign w_last = 1'b1;
    end else begin : g_cnt
      logic [LOG2_AVG-1:0] r_cnt;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt <= '0;
        end else if (!i_en) begin
          r_cnt <= '0;
        end else if (w_stb) begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
      end

      assign w_last = &r_cnt;
    end
  endgenerate

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_full  = (r_count == LW'(FIFO_DEPTH));
  assign w_pop   = (r_count != '0) & rd_if.dready;
  assign w_write = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_write && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_ovf        = r_ovf;
  assign rd_if.dvalid = (r_count != '0);
  assign rd_if.dout   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign rd_if.level  = r_count;

endmodule

// File: tb/tb_sar_avg_fifo.sv
// Bench for sar_avg_fifo: a pass-through instance and a 4-sample averaging instance
// share one stimulus stream; a cycle model with expected-word queues checks both.
module tb_sar_avg_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cko;
  logic       clrOvf;
  logic [9:0] data;
  logic       ovf0;
  logic       ovf2;

  always #5 clk = ~clk;

  sar_avg_fifo_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
  sar_avg_fifo_if #(.FIFO_DEPTH(DEPTH)) bus2 ();

  sar_avg_fifo #(.LOG2_AVG(0), .FIFO_DEPTH(DEPTH)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cko(cko), .i_data(data),
    .i_clr_ovf(clrOvf), .o_ovf(ovf0), .rd_if(bus0.master)
  );

  sar_avg_fifo #(.LOG2_AVG(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cko(cko), .i_data(data),
    .i_clr_ovf(clrOvf), .o_ovf(ovf2), .rd_if(bus2.master)
  );

  int vectorCount = 0;
  int miscompareCount = 0;

  // Model state, index 0 = pass-through instance, index 1 = averaging instance.
  int         mLvl [2];
  logic       mOvf [2];
  int         mAcc [2];
  int         mCnt [2];
  logic [9:0] q0 [$];
  logic [9:0] q2 [$];
  int         armDelay = 0;
  logic [9:0] sampleVal;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Every negedge: compare outputs against the model, then advance the model by one edge.
  always @(negedge clk) begin : monitor
    int   oLvl [2];
    int   oVal [2];
    int   oDout [2];
    int   oOvf [2];
    int   rdy [2];
    int   l2;
    int   word;
    int   expDout;
    logic fire;
    logic pop;
    logic drop;
    logic haveWord;

    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mLvl[k] = 0;
        mOvf[k] = 1'b0;
        mAcc[k] = 0;
        mCnt[k] = 0;
      end
      q0.delete();
      q2.delete();
      armDelay = 0;
    end else begin
      oLvl[0] = int'(bus0.level);  oLvl[1] = int'(bus2.level);
      oVal[0] = int'(bus0.dvalid); oVal[1] = int'(bus2.dvalid);
      oDout[0] = int'(bus0.dout);  oDout[1] = int'(bus2.dout);
      oOvf[0] = int'(ovf0);        oOvf[1] = int'(ovf2);
      rdy[0] = int'(bus0.dready);  rdy[1] = int'(bus2.dready);

      fire = 1'b0;
      if (armDelay > 0) begin
        armDelay--;
        fire = (armDelay == 0);
      end

      for (int k = 0; k < 2; k++) begin
        l2 = (k == 0) ? 0 : 2;
        if (k == 0) expDout = (q0.size() > 0) ? int'(q0[0]) : 0;
        else        expDout = (q2.size() > 0) ? int'(q2[0]) : 0;
        checkOutput($sformatf("dut%0d.level", l2), oLvl[k], mLvl[k]);
        checkOutput($sformatf("dut%0d.dvalid", l2), oVal[k], (mLvl[k] > 0) ? 1 : 0);
        checkOutput($sformatf("dut%0d.dout", l2), oDout[k], expDout);
        checkOutput($sformatf("dut%0d.ovf", l2), oOvf[k], int'(mOvf[k]));

        pop = (mLvl[k] > 0) && (rdy[k] != 0);
        if (pop) begin
          if (k == 0) void'(q0.pop_front());
          else        void'(q2.pop_front());
        end

        haveWord = 1'b0;
        word = 0;
        if (fire && en) begin
          if (mCnt[k] < (1 << l2) - 1) begin
            mAcc[k] += int'(sampleVal);
            mCnt[k]++;
          end else begin
            word = (mAcc[k] + int'(sampleVal)) >> l2;
            haveWord = 1'b1;
            mAcc[k] = 0;
            mCnt[k] = 0;
          end
        end

        drop = 1'b0;
        if (haveWord) begin
          if (mLvl[k] < DEPTH || pop) begin
            if (k == 0) q0.push_back(word[9:0]);
            else        q2.push_back(word[9:0]);
            mLvl[k]++;
          end else begin
            drop = 1'b1;
          end
        end
        if (pop) mLvl[k]--;

        if (drop)        mOvf[k] = 1'b1;
        else if (clrOvf) mOvf[k] = 1'b0;

        if (!en) begin
          mAcc[k] = 0;
          mCnt[k] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One conversion: CKO high for 2 cycles, low for 3, DATA held from the rise onwards.
  task automatic applyStimulus(input logic [9:0] v, input bit popOnPush);
    tick();
    data      = v;
    sampleVal = v;
    cko       = 1'b1;
    armDelay  = 3;
    tick();
    tick();
    cko = 1'b0;
    if (popOnPush) begin
      bus0.dready = 1'b1;
      bus2.dready = 1'b1;
    end
    tick();
    if (popOnPush) begin
      bus0.dready = 1'b0;
      bus2.dready = 1'b0;
    end
    tick();
  endtask

  task automatic checkAllZero(input string phase);
    checkOutput({phase, ".dut0.level"}, int'(bus0.level), 0);
    checkOutput({phase, ".dut0.dvalid"}, int'(bus0.dvalid), 0);
    checkOutput({phase, ".dut0.dout"}, int'(bus0.dout), 0);
    checkOutput({phase, ".dut0.ovf"}, int'(ovf0), 0);
    checkOutput({phase, ".dut2.level"}, int'(bus2.level), 0);
    checkOutput({phase, ".dut2.dvalid"}, int'(bus2.dvalid), 0);
    checkOutput({phase, ".dut2.dout"}, int'(bus2.dout), 0);
    checkOutput({phase, ".dut2.ovf"}, int'(ovf2), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    cko         = 1'b0;
    data        = '0;
    sampleVal   = '0;
    clrOvf      = 1'b0;
    bus0.dready = 1'b0;
    bus2.dready = 1'b0;

    #12;
    checkAllZero("reset");
    waitCycles(2);
    rst_n = 1'b1;
    tick();
    en          = 1'b1;
    bus0.dready = 1'b1;
    bus2.dready = 1'b1;

    // Pass-through extremes; the averager keeps a 2-sample partial group.
    applyStimulus(10'h3FF, 1'b0);
    applyStimulus(10'h001, 1'b0);
    waitCycles(3);

    // Disabling discards that partial group before the group of 8s.
    en = 1'b0;
    waitCycles(3);
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) applyStimulus(10'd8, 1'b0);

    applyStimulus(10'd10, 1'b0);
    applyStimulus(10'd11, 1'b0);
    applyStimulus(10'd12, 1'b0);
    applyStimulus(10'd14, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(10'h3FF, 1'b0);
    waitCycles(3);

    // Five groups with no consumer: the fifth word is dropped and OVF set.
    bus0.dready = 1'b0;
    bus2.dready = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(10'($urandom_range(0, 1023)), 1'b0);
    waitCycles(2);
    clrOvf = 1'b1;
    tick();
    clrOvf = 1'b0;
    tick();

    // Push into a full FIFO on the same edge as a pop.
    for (int i = 0; i < 3; i++) applyStimulus(10'($urandom_range(0, 1023)), 1'b0);
    applyStimulus(10'h2A5, 1'b1);
    waitCycles(2);
    bus0.dready = 1'b1;
    bus2.dready = 1'b1;
    waitCycles(8);

    // Build LEVEL=3 plus a partial group, then reset between edges.
    bus2.dready = 1'b0;
    for (int i = 0; i < 14; i++) applyStimulus(10'($urandom_range(0, 1023)), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("asyncrst");
    tick();
    tick();
    rst_n       = 1'b1;
    bus2.dready = 1'b1;
    tick();
    applyStimulus(10'h3FF, 1'b0);
    applyStimulus(10'h001, 1'b0);
    waitCycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
